// File: rtl/mips_pkg.sv
// Shared definitions for the pipe_MIPS32 core: memory geometry defaults,
// the arbiter's read-owner encoding and the instruction opcode constants.
package mips_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
  localparam int RUN_W      = 4;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    RD_IF = 2'd1,
    RD_DM = 2'd2
  } rd_owner_e;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

endpackage

// File: rtl/mips_arb_prio.sv
// Grant priority: data wins a contested cycle until it has won MAX_DATA_RUN
// of them in a row, then fetch gets one cycle. Reset suppresses all grants.
module mips_arb_prio
  import mips_pkg::*;
#(
  parameter int MAX_DATA_RUN = 4
) (
  input  logic             reset,
  input  logic             if_req,
  input  logic             dm_req,
  input  logic [RUN_W-1:0] run_cnt,
  output logic             if_gnt,
  output logic             dm_gnt
);

  // Combinational grant decision from requests and the contested-run count.
  always_comb begin
    dm_gnt = ~reset & dm_req & (~if_req | (run_cnt < RUN_W'(MAX_DATA_RUN)));
    if_gnt = ~reset & if_req & ~dm_gnt;
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Shares the single-port unified memory between instruction fetch and
// load/store. One access per cycle; read data is routed back to its owner
// one cycle after the strobe.
//
// state | meaning
// NONE  | no read return expected this cycle
// RD_IF | mem_rdata belongs to fetch (unless flushed)
// RD_DM | mem_rdata belongs to a load
module mips_mem_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  rd_owner_e        owner, owner_next;
  logic [RUN_W-1:0] run_cnt;
  logic             if_flush_q;

  mips_arb_prio #(.MAX_DATA_RUN(MAX_DATA_RUN)) u_prio (
    .reset   (reset),
    .if_req  (if_req),
    .dm_req  (dm_req),
    .run_cnt (run_cnt),
    .if_gnt  (if_gnt),
    .dm_gnt  (dm_gnt)
  );

  // Count consecutive contested data wins; any fetch grant or idle fetch side restarts it.
  always_ff @(posedge clk1) begin
    if (reset) begin
      run_cnt <= '0;
    end else if (if_gnt || !if_req) begin
      run_cnt <= '0;
    end else if (dm_gnt && (run_cnt != RUN_W'(MAX_DATA_RUN))) begin
      run_cnt <= run_cnt + 1'b1;
    end
  end

  // Read-owner state register plus the flush seen in the fetch grant cycle.
  always_ff @(posedge clk1) begin
    if (reset) begin
      owner      <= NONE;
      if_flush_q <= 1'b0;
    end else begin
      owner      <= owner_next;
      if_flush_q <= if_gnt & if_flush;
    end
  end

  // Next owner: whoever strobed a read this cycle; stores and idle return nothing.
  always_comb begin
    owner_next = NONE;
    if (if_gnt) begin
      owner_next = RD_IF;
    end else if (dm_gnt && !dm_we) begin
      owner_next = RD_DM;
    end
  end

  // Memory drive, stalls and read-return routing; reset forces every output low.
  always_comb begin
    mem_en    = if_gnt | dm_gnt;
    mem_we    = dm_gnt & dm_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dm_gnt) begin
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
    end
    if_stall  = ~reset & if_req & ~if_gnt;
    dm_stall  = ~reset & dm_req & ~dm_gnt;
    if_rvalid = ~reset & (owner == RD_IF) & ~(if_flush_q | if_flush);
    dm_rvalid = ~reset & (owner == RD_DM);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    dm_rdata  = dm_rvalid ? mem_rdata : '0;
  end

endmodule

// File: doc/mips_mem_arbiter.md
# mips_mem_arbiter

Arbiter that shares the single-port unified instruction/data memory of the `pipe_MIPS32` core between two requesters: instruction fetch (IF stage) and load/store (MEM stage). It grants one access per cycle, returns synchronous read data to the correct owner one cycle later, and produces per-port stall signals that the pipeline uses to freeze. Data accesses win by default, and a bounded-run rule guarantees fetch progress. It sits between the pipeline stage registers and the `MEM` array.

## Interface
Parameters:
- `ADDR_W`, 10, word-address width (1024-word memory)
- `DATA_W`, 32, word width
- `MAX_DATA_RUN`, 4, consecutive contested data grants allowed before fetch is forced through (range 1-15)

Ports:
- `clk1`  in  1  single clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high
- `if_req`  in  1  fetch read request
- `if_addr`  in  ADDR_W  fetch word address
- `if_flush`  in  1  taken branch; discard any fetch read in flight
- `if_gnt`  out  1  fetch access issued this cycle
- `if_rvalid`  out  1  `if_rdata` valid
- `if_rdata`  out  DATA_W  fetched instruction
- `if_stall`  out  1  `if_req & ~if_gnt`
- `dm_req`  in  1  data access request
- `dm_we`  in  1  1 = store (SW), 0 = load (LW)
- `dm_addr`  in  ADDR_W  data word address
- `dm_wdata`  in  DATA_W  store data
- `dm_gnt`  out  1  data access issued this cycle
- `dm_rvalid`  out  1  `dm_rdata` valid (loads only)
- `dm_rdata`  out  DATA_W  load data
- `dm_stall`  out  1  `dm_req & ~dm_gnt`
- `mem_en`, `mem_we`  out  1  memory strobe / write enable
- `mem_addr`  out  ADDR_W; `mem_wdata`  out  DATA_W
- `mem_rdata`  in  DATA_W  memory read data, valid 1 cycle after a read strobe

## Operation
- Grant is combinational from the requests and the registered state. At most one of `if_gnt` / `dm_gnt` is high in any cycle.
- Priority:
  - only one request → that port is granted;
  - both requests and `run_cnt < MAX_DATA_RUN` → data is granted;
  - both requests and `run_cnt == MAX_DATA_RUN` → fetch is granted.
- `run_cnt` (4 bits):
  - +1 on a data grant while `if_req` = 1;
  - cleared on any fetch grant, or in any cycle with `if_req` = 0;
  - saturates at `MAX_DATA_RUN`.
- Memory drive:
  - `mem_en` = `if_gnt | dm_gnt`;
  - `mem_we` = `dm_gnt & dm_we`;
  - `mem_addr` / `mem_wdata` are muxed from the granted port;
  - all are 0 when idle.
- Read-owner FSM, registered: `NONE`, `RD_IF`, `RD_DM`.
  - Next state is `RD_IF` on a fetch grant, `RD_DM` on a load grant, and `NONE` otherwise (store or idle).
- Read return in state `RD_IF`: `if_rvalid` = `~if_flush_q`, where `if_flush_q` is `if_flush` registered at the grant cycle OR'd with the current `if_flush`.
- Read return in state `RD_DM`: `dm_rvalid` = 1.
- `if_rdata` / `dm_rdata` = `mem_rdata` when the port's rvalid is high, 0 otherwise.
- Stores produce no rvalid; the write completes in the grant cycle.

## Timing
- Reset: every output is 0, FSM is `NONE`, `run_cnt` = 0, `if_flush_q` = 0. Reset overrides requests in the same cycle: no grant is issued.
- Reset asserted while in `RD_IF` / `RD_DM` drops the return; no rvalid follows reset.
- Grant-to-data latency: exactly 1 cycle. Back-to-back grants are legal every cycle; the owner alternates accordingly.
- A requester must hold its `req`, address and data stable until it sees `gnt`. `gnt` is high for exactly the cycle of issue.
- A flush in the grant cycle or in the return cycle kills that fetch return. A flush with no fetch in flight has no effect.
- `if_flush` and `if_req` high in the same cycle: the new fetch is still granted, but its return is killed. The pipeline re-requests from the branch target the next cycle.
- `MAX_DATA_RUN` = 1: contested cycles alternate strictly D, F, D, F.

## Structure
- Shared package `mips_pkg`:
  - `ADDR_W` / `DATA_W` defaults;
  - read-owner enum (`NONE`, `RD_IF`, `RD_DM`);
  - opcode constants, for reuse by the pipeline decoder and benches (ADD=000000 … LW=001000, SW=001001, HLT=111111).
- Single flat module. The priority plus `run_cnt` logic may be split into sub-module `mips_arb_prio` (inputs: requests and `run_cnt`; outputs: grants).

## Test plan
- Fetch only: `if_req` at addrs 0..4 with MEM[0..4] preloaded → `if_gnt` every cycle, `if_rvalid` one cycle later, `if_rdata` = MEM[n] in order, `if_stall` = 0.
- Contention: `if_req` held while a store to addr 100 with `dm_wdata` = 30 is issued → `dm_gnt` first, `if_stall` = 1 for 1 cycle, then MEM[100] = 30 and the fetch is granted next cycle.
- Starvation bound, `MAX_DATA_RUN` = 4: both requesters held for 10 cycles → grant pattern D D D D F D D D D F; `dm_stall` high only on the F cycles.
- Load return: load at addr 100 (holding 30), immediately followed by a fetch → `dm_rvalid` = 1 with `dm_rdata` = 30, then `if_rvalid` next cycle; the two rvalids never coincide.
- Flush: fetch granted at cycle t, `if_flush` = 1 at t+1 → `if_rvalid` = 0 at t+1, and the next fetch (branch target) returns normally.
- Reset mid-operation: `reset` asserted in the cycle after a load grant → `dm_rvalid` = 0, all outputs 0, `run_cnt` = 0; after release, the first fetch at addr 0 returns MEM[0].
